// File: rtl/aes_core_if.sv
// AES-128 encrypt request/result bundle: start/key/plaintext in, busy/done/cyphertext out.
// Purely combinational wiring; carries no state and adds no latency.
// No backpressure signals; the core drops a start that arrives while busy. last_key exists only under AES_CORE_LASTKEY_EN.
interface aes_core_if #(
    parameter int K = 128
);
    logic           start;
    logic [K-1:0]   key;
    logic [127:0]   plaintext;
    logic           busy;
    logic           done;
    logic [127:0]   cyphertext;
`ifdef AES_CORE_LASTKEY_EN
    logic [127:0]   last_key;

    modport master (output start, key, plaintext, input busy, done, cyphertext, last_key);
    modport slave  (input start, key, plaintext, output busy, done, cyphertext, last_key);
`else
    modport master (output start, key, plaintext, input busy, done, cyphertext);
    modport slave  (input start, key, plaintext, output busy, done, cyphertext);
`endif
endinterface

// File: rtl/aes_core.sv
// Iterative AES-128 encryptor: one cipher round per clock, with the key schedule expanded on the fly.
// The edge that samples start loads the state. done is registered 10 edges later and lasts 1 cycle; pulses are 11 cycles apart back-to-back.
// No backpressure: start is ignored while busy, with no queuing. Optional AES_CORE_LASTKEY_EN exports the round-10 key.
module aes_core #(
    parameter int K = 128
) (
    input  logic      clk,
    input  logic      reset,
    aes_core_if.slave bus
);
    if (K != 128) begin : g_bad_key_len
        $error("aes_core: K=%0d is not supported, only 128", K);
    end

    // S-box, byte 0x00 in the top byte.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TBL[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // SubBytes and ShiftRows together; byte (row r, col c) sits at index r + 4c.
    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(r+4*c) -: 8] = sbox(s[127-8*(r+4*((c+r)%4)) -: 8]);
            end
        end
        return o;
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            o[127-32*c -: 32] = mix_col(s[127-32*c -: 32]);
        end
        return o;
    endfunction

    function automatic logic [127:0] expand_key(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, rot, t, n0, n1, n2, n3;
        {w0, w1, w2, w3} = k;
        rot = {w3[23:0], w3[31:24]};
        t   = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])} ^ {rc, 24'h0};
        n0  = w0 ^ t;
        n1  = w1 ^ n0;
        n2  = w2 ^ n1;
        n3  = w3 ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    state_t       state;
    logic [3:0]   round;
    logic [127:0] st;
    logic [127:0] rk;
    logic [127:0] next_rk;
    logic [127:0] sb_sr;
    logic [127:0] round_out;
    logic [127:0] cyph_q;
    logic         busy_q;
    logic         done_q;
`ifdef AES_CORE_LASTKEY_EN
    logic [127:0] last_key_q;
    assign bus.last_key = last_key_q;
`endif

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.cyphertext = cyph_q;

    // One full cipher round plus the matching round key; the final round skips MixColumns.
    always_comb begin
        sb_sr     = sub_shift(st);
        next_rk   = expand_key(rk, rcon(round));
        round_out = ((round == 4'd10) ? sb_sr : mix_columns(sb_sr)) ^ next_rk;
    end

    // Control FSM with registered busy/done; the result registers load only on entry to DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            round      <= 4'd0;
            st         <= '0;
            rk         <= '0;
            cyph_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef AES_CORE_LASTKEY_EN
            last_key_q <= '0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        st     <= bus.plaintext ^ bus.key;
                        rk     <= bus.key;
                        round  <= 4'd1;
                        busy_q <= 1'b1;
                        state  <= ROUND;
                    end else begin
                        state  <= IDLE;
                    end
                end
                ROUND: begin
                    st <= round_out;
                    rk <= next_rk;
                    if (round == 4'd10) begin
                        cyph_q     <= round_out;
`ifdef AES_CORE_LASTKEY_EN
                        last_key_q <= next_rk;
`endif
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        state      <= DONE;
                    end else begin
                        round <= round + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_core.sv
// Directed bench for aes_core: FIPS-197 App. B / C.1 vectors, ignored start, back-to-back and reset abort.
// A scoreboard queue receives the expected result for every operation that should complete; the monitor pops it on each done.
// Inputs change #1 after the rising edge, and the monitor samples on the falling edge.
module tb_aes_core;
    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] LK_B  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] LK_C  = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    typedef struct {
        logic [127:0] ct;
        logic [127:0] lk;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    aes_core_if bus ();
    aes_core dut (.clk(clk), .reset(reset), .bus(bus));

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   errors   = 0;
    int   cyc      = 0;
    int   done_cnt = 0;
    int   cap, at, bn, d0, n;
    int   at_list[3];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // Each done pops one expected result; a done with nothing pending is an error.
    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            done_cnt++;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 with no result pending, required done=0");
            end else begin
                mon_e = sb_q.pop_front();
                chk("cyphertext", bus.cyphertext, mon_e.ct);
`ifdef AES_CORE_LASTKEY_EN
                chk("last_key", bus.last_key, mon_e.lk);
`endif
            end
        end
    end

    // Raise start; the next rising edge captures it, and we return #1 after that edge with start low again.
    task automatic launch(input logic [127:0] k, input logic [127:0] p, input bit expect_done,
                          input logic [127:0] ct, input logic [127:0] lk, output int cap_cyc);
        bus.start     = 1'b1;
        bus.key       = k;
        bus.plaintext = p;
        if (expect_done) sb_q.push_back('{ct, lk});
        @(posedge clk);
        #1;
        cap_cyc   = cyc;
        bus.start = 1'b0;
    endtask

    // Step edge by edge until done is seen, counting busy cycles on the way.
    task automatic wait_done(input string name, output int busy_n, output int at_cyc);
        bit seen;
        seen   = 1'b0;
        busy_n = 0;
        at_cyc = -1;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (bus.done === 1'b1) begin
                seen   = 1'b1;
                at_cyc = cyc;
            end else begin
                if (bus.busy === 1'b1) busy_n++;
                @(posedge clk);
                #1;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got done=0 for 40 cycles, required done=1", name);
        end
    endtask

    initial begin
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.key       = '0;
        bus.plaintext = '0;
        #12;
        chk_int("reset_busy", int'(bus.busy), 0);
        chk_int("reset_done", int'(bus.done), 0);
        chk("reset_cyphertext", bus.cyphertext, 128'd0);
`ifdef AES_CORE_LASTKEY_EN
        chk("reset_last_key", bus.last_key, 128'd0);
`endif
        @(posedge clk);
        #1;
        reset = 1'b0;

        // App. B on the first edge after reset; the inputs go to all ones right after capture.
        launch(KEY_B, PT_B, 1'b1, CT_B, LK_B, cap);
        bus.key       = '1;
        bus.plaintext = '1;
        chk_int("b_busy_after_capture", int'(bus.busy), 1);
        wait_done("b", bn, at);
        // The capture edge counts as edge 1, so done rises on edge 11, ten edges later.
        chk_int("b_latency", at - cap, 10);
        chk_int("b_busy_cycles", bn, 10);
        @(posedge clk);
        #1;
        chk_int("b_done_one_cycle", int'(bus.done), 0);
        chk_int("b_idle_busy", int'(bus.busy), 0);
        chk("b_cyphertext_hold", bus.cyphertext, CT_B);

        // App. C.1 on its own.
        launch(KEY_C, PT_C, 1'b1, CT_C, LK_C, cap);
        wait_done("c1", bn, at);
        chk_int("c1_latency", at - cap, 10);
        chk_int("c1_busy_cycles", bn, 10);
        @(posedge clk);
        #1;

        // App. B with a stray C.1 start at round 5: only the App. B result may appear.
        d0 = done_cnt;
        launch(KEY_B, PT_B, 1'b1, CT_B, LK_B, cap);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        bus.start     = 1'b1;
        bus.key       = KEY_C;
        bus.plaintext = PT_C;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done("ignore", bn, at);
        chk_int("ignore_latency", at - cap, 10);
        repeat (15) begin
            @(posedge clk);
            #1;
        end
        chk_int("ignore_done_count", done_cnt - d0, 1);
        chk("ignore_cyphertext", bus.cyphertext, CT_B);

        // start held high: back-to-back C.1 with done every 11 cycles.
        d0 = done_cnt;
        sb_q.push_back('{CT_C, LK_C});
        sb_q.push_back('{CT_C, LK_C});
        bus.start     = 1'b1;
        bus.key       = KEY_C;
        bus.plaintext = PT_C;
        launch(KEY_C, PT_C, 1'b1, CT_C, LK_C, cap);
        bus.start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_done("b2b", bn, at_list[k]);
            chk_int("b2b_busy_cycles", bn, 10);
            if (k == 2) bus.start = 1'b0;
            @(posedge clk);
            #1;
        end
        chk_int("b2b_first_latency", at_list[0] - cap, 10);
        chk_int("b2b_spacing_1", at_list[1] - at_list[0], 11);
        chk_int("b2b_spacing_2", at_list[2] - at_list[1], 11);
        chk_int("b2b_stops_busy", int'(bus.busy), 0);
        repeat (12) begin
            @(posedge clk);
            #1;
        end
        chk_int("b2b_done_count", done_cnt - d0, 3);

        // Reset at round 7 of App. B aborts it; C.1 follows on the first edge after release.
        d0 = done_cnt;
        launch(KEY_B, PT_B, 1'b0, CT_B, LK_B, cap);
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        #1;
        chk_int("abort_busy", int'(bus.busy), 0);
        chk_int("abort_done", int'(bus.done), 0);
        chk("abort_cyphertext", bus.cyphertext, 128'd0);
`ifdef AES_CORE_LASTKEY_EN
        chk("abort_last_key", bus.last_key, 128'd0);
`endif
        @(posedge clk);
        #1;
        reset = 1'b0;
        launch(KEY_C, PT_C, 1'b1, CT_C, LK_C, cap);
        n = 0;
        while (bus.done !== 1'b1 && n < 40) begin
            chk("abort_cyphertext_zero", bus.cyphertext, 128'd0);
            @(posedge clk);
            #1;
            n++;
        end
        chk_int("abort_c1_latency", cyc - cap, 10);
        @(posedge clk);
        #1;
        chk_int("abort_done_count", done_cnt - d0, 1);
        chk("abort_c1_cyphertext", bus.cyphertext, CT_C);

        chk_int("scoreboard_empty", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
